// File: rtl/jk_arb_pkg.sv
// Shared types and constants for the JK flop-bank arbiter.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } jk_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int TOGGLE_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of NFF JK flops written by NREQ round-robin-arbitrated requesters.
// Define JK_ARB_TOGGLE_CNT_EN to add the saturating toggle_cnt output.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = $clog2(NFF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [2*NREQ-1:0]      req_jk,
    input  logic [IDXW*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   clr_all,
    output logic [NFF-1:0]         q,
    output logic [NREQ-1:0]        grant,
    output logic                   busy
`ifdef JK_ARB_TOGGLE_CNT_EN
    ,
    output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   arb_gnt;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d, ptr_next;
    logic [NFF-1:0]    q_q, q_d;
    logic [1:0]        sel_jk;
    logic [IDXW-1:0]   sel_idx;
    logic              hs;
    logic              idx_ok;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .gnt    (arb_gnt)
    );

    // Mux the granted requester's fields; grant_q is one-hot or zero.
    always_comb begin
        sel_jk   = '0;
        sel_idx  = '0;
        ptr_next = rr_ptr_q;
        for (int r = 0; r < NREQ; r++) begin
            if (grant_q[r]) begin
                sel_jk   = req_jk[2*r +: 2];
                sel_idx  = req_idx[IDXW*r +: IDXW];
                ptr_next = PW'((r + 1) % NREQ);
            end
        end
    end

    assign hs     = (state_q == ST_GRANT) && |(req_valid & grant_q);
    assign idx_ok = {1'b0, sel_idx} < (IDXW+1)'(NFF);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = arb_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A withdrawn requester keeps its priority: pointer only moves on a handshake.
                if (hs) rr_ptr_d = ptr_next;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        q_d = q_q;
        if (hs && idx_ok) begin
            case (jk_op_t'(sel_jk))
                OP_RST:  q_d[sel_idx] = 1'b0;
                OP_SET:  q_d[sel_idx] = 1'b1;
                OP_TGL:  q_d[sel_idx] = ~q_q[sel_idx];
                default: q_d[sel_idx] = q_q[sel_idx];
            endcase
        end
        if (clr_all) q_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            q_q      <= q_d;
        end
    end

`ifdef JK_ARB_TOGGLE_CNT_EN
    logic [TOGGLE_CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;

    always_comb begin
        toggle_cnt_d = toggle_cnt_q;
        if (hs && idx_ok && !clr_all && (jk_op_t'(sel_jk) == OP_TGL) && (toggle_cnt_q != '1))
            toggle_cnt_d = toggle_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) toggle_cnt_q <= '0;
        else        toggle_cnt_q <= toggle_cnt_d;
    end

    assign toggle_cnt = toggle_cnt_q;
`endif

    assign q         = q_q;
    assign grant     = grant_q;
    assign req_ready = grant_q;
    assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench: an 8-flop and a 6-flop bank share stimulus and are compared to a behavioural model.
module tb_jk_bank_arbiter;

    localparam int NREQ = 4;
    localparam int IDXW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_jk;
    logic [IDXW*NREQ-1:0] req_idx;
    logic                 clr_all;

    logic [7:0]      q8;
    logic [5:0]      q6;
    logic [NREQ-1:0] grant8, grant6, ready8, ready6;
    logic            busy8, busy6;
`ifdef JK_ARB_TOGGLE_CNT_EN
    logic [15:0]     tc8, tc6;
`endif

    jk_bank_arbiter #(.NREQ(NREQ), .NFF(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_jk(req_jk), .req_idx(req_idx),
        .req_ready(ready8), .clr_all(clr_all), .q(q8), .grant(grant8), .busy(busy8)
`ifdef JK_ARB_TOGGLE_CNT_EN
        , .toggle_cnt(tc8)
`endif
    );

    jk_bank_arbiter #(.NREQ(NREQ), .NFF(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_jk(req_jk), .req_idx(req_idx),
        .req_ready(ready6), .clr_all(clr_all), .q(q6), .grant(grant6), .busy(busy6)
`ifdef JK_ARB_TOGGLE_CNT_EN
        , .toggle_cnt(tc6)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: granted requester (-1 when idle), priority pointer, flop banks, toggle counts.
    int          m_g;
    int          m_ptr;
    logic [63:0] m_q8, m_q6;
    int          m_tc8, m_tc6;
    logic [3:0]  m_hs_mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] apply_op(input logic [63:0] v, input int n, input int op, input int ix);
        logic [63:0] r;
        r = v;
        if (ix < n) begin
            case (op)
                1: r[ix] = 1'b0;
                2: r[ix] = 1'b1;
                3: r[ix] = ~v[ix];
                default: r[ix] = v[ix];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_g = -1; m_ptr = 0; m_q8 = '0; m_q6 = '0; m_tc8 = 0; m_tc6 = 0; m_hs_mask = '0;
    endtask

    task automatic model_step();
        m_hs_mask = '0;
        if (m_g < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_ptr + i) % NREQ;
                if (req_valid[j]) begin
                    m_g = j;
                    break;
                end
            end
        end else begin
            int g;
            int op;
            int ix;
            g  = m_g;
            op = int'(req_jk[2*g +: 2]);
            ix = int'(req_idx[IDXW*g +: IDXW]);
            if (req_valid[g]) begin
                m_hs_mask[g] = 1'b1;
                if (!clr_all) begin
                    m_q8 = apply_op(m_q8, 8, op, ix);
                    m_q6 = apply_op(m_q6, 6, op, ix);
                    if (op == 3 && ix < 8 && m_tc8 < 65535) m_tc8++;
                    if (op == 3 && ix < 6 && m_tc6 < 65535) m_tc6++;
                end
                m_ptr = (g + 1) % NREQ;
            end
            m_g = -1;
        end
        if (clr_all) begin
            m_q8 = '0;
            m_q6 = '0;
        end
    endtask

    task automatic compare();
        logic [3:0] eg;
        eg = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
        chk("q8", 64'(q8), m_q8);
        chk("q6", 64'(q6), m_q6);
        chk("grant8", 64'(grant8), 64'(eg));
        chk("ready8", 64'(ready8), 64'(eg));
        chk("grant6", 64'(grant6), 64'(eg));
        chk("ready6", 64'(ready6), 64'(eg));
        chk("busy8", 64'(busy8), 64'(m_g >= 0));
        chk("busy6", 64'(busy6), 64'(m_g >= 0));
`ifdef JK_ARB_TOGGLE_CNT_EN
        chk("toggle_cnt8", 64'(tc8), 64'(m_tc8));
        chk("toggle_cnt6", 64'(tc6), 64'(m_tc6));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] jk, input logic [2:0] ix);
        req_valid[r]          = v;
        req_jk[2*r +: 2]      = jk;
        req_idx[IDXW*r +: IDXW] = ix;
    endtask

    task automatic do_op(input int r, input logic [1:0] jk, input logic [2:0] ix);
        set_req(r, 1'b1, jk, ix);
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (m_hs_mask[r]) break;
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0; clr_all = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_jk = '0; req_idx = '0; clr_all = 1'b0;
        model_reset();
        #3;
        compare();
        chk("reset_q", 64'(q8), 64'h0);
        chk("reset_grant", 64'(grant8), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single set on idx 3.
        set_req(0, 1'b1, 2'b10, 3'd3);
        cycle();
        chk("single_grant", 64'(grant8), 64'h1);
        chk("single_ready", 64'(ready8), 64'h1);
        cycle();
        chk("single_q", 64'(q8), 64'h08);
        chk("single_grant_clr", 64'(grant8), 64'h0);
        req_valid = '0;
        cycle();

        // Round robin with all four toggling their own index.
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 2'b11, 3'(r));
        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (c % 2 == 1) chk("rr_grant", 64'(grant8), 64'(1 << (((c - 1) / 2) % NREQ)));
            else            chk("rr_gap", 64'(grant8), 64'h0);
            if (c == 8)  chk("rr_q4", 64'(q8), 64'h0F);
            if (c == 10) chk("rr_q5", 64'(q8), 64'h0E);
        end
        req_valid = '0;
        cycle();

        // Withdrawal of req1 leaves its priority intact.
        set_req(1, 1'b1, 2'b11, 3'd5);
        cycle();
        chk("wd_grant", 64'(grant8), 64'h2);
        req_valid[1] = 1'b0;
        cycle();
        chk("wd_grant_drop", 64'(grant8), 64'h0);
        chk("wd_q", 64'(q8), 64'h0E);
        set_req(1, 1'b1, 2'b11, 3'd5);
        set_req(2, 1'b1, 2'b10, 3'd6);
        cycle();
        chk("wd_rewin", 64'(grant8), 64'h2);
        cycle();
        chk("wd_q_after", 64'(q8), 64'h2E);
        req_valid[1] = 1'b0;
        cycle();
        chk("wd_next", 64'(grant8), 64'h4);
        cycle();
        chk("wd_q2", 64'(q8), 64'h6E);
        req_valid = '0;

        // clr_all colliding with a handshake.
        for (int i = 0; i < 8; i++) do_op(0, 2'b10, 3'(i));
        chk("clr_pre_q", 64'(q8), 64'hFF);
        set_req(0, 1'b1, 2'b10, 3'd0);
        cycle();
        clr_all = 1'b1;
        chk("clr_ready", 64'(ready8), 64'h1);
        cycle();
        chk("clr_q", 64'(q8), 64'h00);
        chk("clr_grant", 64'(grant8), 64'h0);
        clr_all = 1'b0;
        req_valid = '0;

        // Hold and reset opcodes.
        do_op(0, 2'b10, 3'd0);
        do_op(0, 2'b10, 3'd2);
        chk("hr_pre", 64'(q8), 64'h05);
        do_op(0, 2'b00, 3'd0);
        chk("hr_hold", 64'(q8), 64'h05);
        do_op(0, 2'b01, 3'd2);
        chk("hr_rst", 64'(q8), 64'h01);

        // Asynchronous reset while granted.
        set_req(3, 1'b1, 2'b11, 3'd4);
        cycle();
        chk("ar_busy", 64'(busy8), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("ar_q", 64'(q8), 64'h0);
        chk("ar_grant", 64'(grant8), 64'h0);
        chk("ar_ready", 64'(ready8), 64'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 2'b11, 3'd1);
        do_op(0, 2'b11, 3'd1);
        do_op(0, 2'b11, 3'd1);
        do_op(0, 2'b10, 3'd2);
        chk("tc_q", 64'(q8), 64'h06);
`ifdef JK_ARB_TOGGLE_CNT_EN
        chk("tc_count", 64'(tc8), 64'd3);
`endif

        // Randomised traffic with stable-until-ready requesters and occasional withdrawals.
        for (int c = 0; c < 3000; c++) begin
            clr_all = ($urandom_range(0, 19) == 0);
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r] && !m_hs_mask[r]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[r] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(r, 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            cycle();
        end
        clr_all = 1'b0;
        req_valid = '0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
